// File: rtl/stopwatch_display_if.sv
// Link between the stop_watch core (master) and its two-digit 7-segment display driver (slave).
// The display-side signal names match the pins of the stopwatch_display block.
interface stopwatch_display_if;
  logic [4:0] time_i;
  logic [2:0] mode_i;
  logic [6:0] seg_o;
  logic [1:0] digit_sel_o;
  logic       dp_o;

  modport master (output time_i, mode_i, input seg_o, digit_sel_o, dp_o);
  modport slave  (input time_i, mode_i, output seg_o, digit_sel_o, dp_o);
endinterface

// File: rtl/stopwatch_display.sv
// Two-digit multiplexed 7-segment driver for the stop watch: decimal split, digit scan, IDLE blink.
// Optional macro STOPWATCH_DISPLAY_LEAD_ZERO_BLANK_EN blanks a leading zero in the tens digit.
module stopwatch_display #(
  parameter int unsigned REFRESH_CYCLES = 1,
  parameter int unsigned BLINK_CYCLES   = 50
) (
  input  logic                clk,
  input  logic                Rst_i,
  stopwatch_display_if.slave  bus
);

  localparam int SCAN_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int BLINK_W = (BLINK_CYCLES   > 1) ? $clog2(BLINK_CYCLES)   : 1;

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(REFRESH_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  localparam logic [2:0] MODE_IDLE    = 3'b100;
  localparam logic [2:0] MODE_CLEAR   = 3'b010;
  localparam logic [2:0] MODE_RUNNING = 3'b001;

  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic { ONES, TENS }     scan_e;
  typedef enum logic { PH_ON, PH_OFF }  blink_e;

  function automatic logic [6:0] seg_of(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_of = 7'h3F;
      4'd1:    seg_of = 7'h06;
      4'd2:    seg_of = 7'h5B;
      4'd3:    seg_of = 7'h4F;
      4'd4:    seg_of = 7'h66;
      4'd5:    seg_of = 7'h6D;
      4'd6:    seg_of = 7'h7D;
      4'd7:    seg_of = 7'h07;
      4'd8:    seg_of = 7'h7F;
      4'd9:    seg_of = 7'h6F;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction

  // Stage 1
  logic [4:0] time_d, time_q;
  logic [2:0] mode_d, mode_q;

  // Scan and blink state
  scan_e               scan_state_d, scan_state_q;
  logic [SCAN_W-1:0]   scan_cnt_d,   scan_cnt_q;
  blink_e              blink_ph_d,   blink_ph_q;
  logic [BLINK_W-1:0]  blink_cnt_d,  blink_cnt_q;

  // Stage 2
  logic [6:0] seg_d,       seg_q;
  logic [1:0] digit_sel_d, digit_sel_q;
  logic       dp_d,        dp_q;

  logic [1:0] tens;
  logic [3:0] ones;
  logic       mode_legal;
  logic       show_tens;

  assign time_d = bus.time_i;
  assign mode_d = bus.mode_i;

  // Decimal split by range comparison; no divider needed for 0..31.
  always_comb begin
    // NOTE: every always_comb output is given a default first so no path can infer a latch.
    tens = 2'd0;
    ones = 4'(time_q);
    if (time_q >= 5'd30) begin
      tens = 2'd3;
      ones = 4'(time_q - 5'd30);
    end else if (time_q >= 5'd20) begin
      tens = 2'd2;
      ones = 4'(time_q - 5'd20);
    end else if (time_q >= 5'd10) begin
      tens = 2'd1;
      ones = 4'(time_q - 5'd10);
    end
  end

  // Scan FSM and blink timer next-state
  always_comb begin
    scan_state_d = scan_state_q;
    scan_cnt_d   = scan_cnt_q + SCAN_W'(1);
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d   = '0;
      scan_state_d = (scan_state_q == ONES) ? TENS : ONES;
    end

    blink_cnt_d = '0;
    blink_ph_d  = PH_ON;
    if (mode_q == MODE_IDLE) begin
      blink_ph_d  = blink_ph_q;
      blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_ph_d  = (blink_ph_q == PH_ON) ? PH_OFF : PH_ON;
      end
    end
  end

  // Outputs are built against the digit that will be selected, keeping sel/seg/dp coherent.
  always_comb begin
    mode_legal  = (mode_q == MODE_IDLE) || (mode_q == MODE_CLEAR) || (mode_q == MODE_RUNNING);
    show_tens   = (scan_state_d == TENS);
    digit_sel_d = show_tens ? 2'b10 : 2'b01;
    seg_d       = SEG_BLANK;
    dp_d        = 1'b0;

    if (!mode_legal) begin
      seg_d = SEG_DASH;
    end else if ((mode_q == MODE_IDLE) && (blink_ph_q == PH_OFF)) begin
      seg_d = SEG_BLANK;
    end else if (show_tens) begin
`ifdef STOPWATCH_DISPLAY_LEAD_ZERO_BLANK_EN
      seg_d = (tens == 2'd0) ? SEG_BLANK : seg_of({2'b00, tens});
`else
      seg_d = seg_of({2'b00, tens});
`endif
    end else begin
      seg_d = seg_of(ones);
      dp_d  = (mode_q == MODE_RUNNING);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (Rst_i) begin
      time_q       <= '0;
      mode_q       <= MODE_IDLE;
      scan_state_q <= ONES;
      scan_cnt_q   <= '0;
      blink_ph_q   <= PH_ON;
      blink_cnt_q  <= '0;
      seg_q        <= SEG_BLANK;
      digit_sel_q  <= 2'b01;
      dp_q         <= 1'b0;
    end else begin
      time_q       <= time_d;
      mode_q       <= mode_d;
      scan_state_q <= scan_state_d;
      scan_cnt_q   <= scan_cnt_d;
      blink_ph_q   <= blink_ph_d;
      blink_cnt_q  <= blink_cnt_d;
      seg_q        <= seg_d;
      digit_sel_q  <= digit_sel_d;
      dp_q         <= dp_d;
    end
  end

  assign bus.seg_o       = seg_q;
  assign bus.digit_sel_o = digit_sel_q;
  assign bus.dp_o        = dp_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// Bench for stopwatch_display: directed vector table, hand-written blink/reset sequences,
// and randomized traffic checked against a cycle-count based reference model.
module tb_stopwatch_display;

  localparam int R = 1;
  localparam int B = 50;

`ifdef STOPWATCH_DISPLAY_LEAD_ZERO_BLANK_EN
  localparam logic [6:0] TENS0 = 7'h00;
`else
  localparam logic [6:0] TENS0 = 7'h3F;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stopwatch_display_if bus ();

  stopwatch_display #(.REFRESH_CYCLES(R), .BLINK_CYCLES(B)) dut (
    .clk   (clk),
    .Rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic       rst;
    logic [4:0] t;
    logic [2:0] m;
    logic [6:0] seg;
    logic [1:0] sel;
    logic       dp;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: edges since reset, consecutive IDLE edges, delayed inputs.
  int         m_edges;
  int         m_idle_run;
  logic [2:0] m_mode;
  int         m_time;
  logic [6:0] seg_tab [10];

  function automatic logic [9:0] act_out();
    return {bus.seg_o, bus.digit_sel_o, bus.dp_o};
  endfunction

  task automatic check(input string name, input int idx, input logic [9:0] act, input logic [9:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got seg=%h sel=%b dp=%b, want seg=%h sel=%b dp=%b",
               name, idx, act[9:3], act[2:1], act[0], exp[9:3], exp[2:1], exp[0]);
    end
  endtask

  // Applies one cycle of inputs and returns the model's expectation for the edge.
  task automatic step(input logic r, input logic [4:0] t, input logic [2:0] m, output logic [9:0] exp);
    logic       tens_sel;
    logic       legal;
    logic [6:0] s;
    logic       d;
    rst         = r;
    bus.time_i  = t;
    bus.mode_i  = m;
    @(posedge clk);
    if (r) begin
      exp        = {7'h00, 2'b01, 1'b0};
      m_edges    = 0;
      m_idle_run = 0;
      m_mode     = 3'b100;
      m_time     = 0;
    end else begin
      m_edges++;
      tens_sel = ((m_edges / R) % 2) == 1;
      legal    = (m_mode == 3'b100) || (m_mode == 3'b010) || (m_mode == 3'b001);
      d        = 1'b0;
      if (!legal) begin
        s = 7'h40;
      end else if (m_mode == 3'b100 && ((m_idle_run / B) % 2) == 1) begin
        s = 7'h00;
      end else if (tens_sel) begin
        s = (m_time / 10 == 0) ? TENS0 : seg_tab[m_time / 10];
      end else begin
        s = seg_tab[m_time % 10];
        d = (m_mode == 3'b001);
      end
      exp        = {s, tens_sel ? 2'b10 : 2'b01, d};
      m_idle_run = (m_mode == 3'b100) ? m_idle_run + 1 : 0;
      m_mode     = m;
      m_time     = int'(t);
    end
    #1;
  endtask

  initial begin
    vec_t       tbl [19];
    logic [9:0] exp;
    logic [6:0] want;
    logic [2:0] cur_m;

    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    tbl[0]  = '{1'b1, 5'd23, 3'b001, 7'h00, 2'b01, 1'b0};
    tbl[1]  = '{1'b1, 5'd23, 3'b001, 7'h00, 2'b01, 1'b0};
    tbl[2]  = '{1'b0, 5'd23, 3'b001, TENS0, 2'b10, 1'b0};
    tbl[3]  = '{1'b0, 5'd23, 3'b001, 7'h4F, 2'b01, 1'b1};
    tbl[4]  = '{1'b0, 5'd23, 3'b001, 7'h5B, 2'b10, 1'b0};
    tbl[5]  = '{1'b0, 5'd9,  3'b001, 7'h4F, 2'b01, 1'b1};
    tbl[6]  = '{1'b0, 5'd9,  3'b001, TENS0, 2'b10, 1'b0};
    tbl[7]  = '{1'b0, 5'd9,  3'b001, 7'h6F, 2'b01, 1'b1};
    tbl[8]  = '{1'b0, 5'd31, 3'b001, TENS0, 2'b10, 1'b0};
    tbl[9]  = '{1'b0, 5'd31, 3'b001, 7'h06, 2'b01, 1'b1};
    tbl[10] = '{1'b0, 5'd31, 3'b011, 7'h4F, 2'b10, 1'b0};
    tbl[11] = '{1'b0, 5'd31, 3'b000, 7'h40, 2'b01, 1'b0};
    tbl[12] = '{1'b0, 5'd4,  3'b010, 7'h40, 2'b10, 1'b0};
    tbl[13] = '{1'b0, 5'd4,  3'b010, 7'h66, 2'b01, 1'b0};
    tbl[14] = '{1'b0, 5'd15, 3'b010, TENS0, 2'b10, 1'b0};
    tbl[15] = '{1'b0, 5'd15, 3'b010, 7'h6D, 2'b01, 1'b0};
    tbl[16] = '{1'b0, 5'd5,  3'b010, 7'h06, 2'b10, 1'b0};
    tbl[17] = '{1'b0, 5'd5,  3'b010, 7'h6D, 2'b01, 1'b0};
    tbl[18] = '{1'b0, 5'd5,  3'b010, TENS0, 2'b10, 1'b0};

    rst        = 1'b1;
    bus.time_i = 5'($urandom_range(0, 31));
    bus.mode_i = 3'($urandom_range(0, 7));

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].rst, tbl[i].t, tbl[i].m, exp);
      check("table", i, act_out(), {tbl[i].seg, tbl[i].sel, tbl[i].dp});
    end

    // IDLE blink: 50 visible edges, 50 blank, repeating; then leave IDLE mid-blank.
    step(1'b0, 5'd7, 3'b100, exp);
    check("idle_enter", 0, act_out(), exp);
    for (int i = 0; i < 160; i++) begin
      step(1'b0, 5'd7, 3'b100, exp);
      if (((i / 50) % 2) == 0) want = (exp[2:1] == 2'b10) ? TENS0 : 7'h07;
      else                     want = 7'h00;
      check("blink", i, act_out(), {want, exp[2:0]});
    end
    step(1'b0, 5'd7, 3'b010, exp);
    check("blink_exit_off", 0, act_out(), {7'h00, exp[2:0]});
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 5'd7, 3'b010, exp);
      want = (exp[2:1] == 2'b10) ? TENS0 : 7'h07;
      check("clear_steady", i, act_out(), {want, exp[2:1], 1'b0});
    end

    // Reset in the middle of operation.
    step(1'b1, 5'd29, 3'b001, exp);
    check("mid_reset", 0, act_out(), {7'h00, 2'b01, 1'b0});
    step(1'b0, 5'd29, 3'b001, exp);
    check("post_reset", 0, act_out(), {TENS0, 2'b10, 1'b0});
    step(1'b0, 5'd29, 3'b001, exp);
    check("post_reset", 1, act_out(), {7'h6F, 2'b01, 1'b1});

    // Randomized traffic against the model; modes persist long enough to exercise blink.
    cur_m = 3'b001;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 7) < 6) begin
          case ($urandom_range(0, 2))
            0:       cur_m = 3'b100;
            1:       cur_m = 3'b010;
            default: cur_m = 3'b001;
          endcase
        end else begin
          cur_m = 3'($urandom_range(0, 7));
        end
      end
      step(($urandom_range(0, 299) == 0), 5'($urandom_range(0, 31)), cur_m, exp);
      check("random", i, act_out(), exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stopwatch_display.md
Name: stopwatch_display

Overview:
Consumer end of the stop_watch output interface: samples time (0–31 s) and the one-hot mode, and drives a 2-digit multiplexed 7-segment display.
- Converts binary time to tens/ones decimal digits.
- Scans the two digits alternately.
- Blinks the display while the stop watch is in IDLE.
- Shows dashes on an illegal (non-one-hot) mode.
- Sits between stop_watch and the board-level display pins in the same 100 Hz clock domain.

Parameters:
- REFRESH_CYCLES, 1: clock cycles each digit stays selected before the scan advances; legal range ≥1.
- BLINK_CYCLES, 50: clock cycles per blink half-period in IDLE (50 cycles = 0.5 s at 100 Hz); legal range ≥1.

Ports:
- clk  input  1  system clock, 100 Hz nominal.
- Rst_i  input  1  reset; synchronous, active-high.
- time_i  input  5  elapsed seconds from stop_watch, unsigned 0–31.
- mode_i  input  3  one-hot mode: IDLE=3'b100, CLEAR=3'b010, RUNNING=3'b001.
- seg_o  output  7  segments {g,f,e,d,c,b,a}, active-high, for the digit currently selected.
- digit_sel_o  output  2  one-hot digit enable: 2'b01 = ones, 2'b10 = tens.
- dp_o  output  1  decimal point / running indicator.

Behaviour:
- One clock (clk). Reset is synchronous and active-high on Rst_i, sampled on the rising edge of clk; there is no asynchronous reset path.
- Reset values: seg_o=7'h00, digit_sel_o=2'b01, dp_o=0, time_q=0, mode_q=3'b100, scan state=ONES, scan counter=0, blink counter=0, blink phase=ON.
- Reset mid-operation forces all of the above on the next edge regardless of inputs.
- Stage 1 register: time_q<=time_i and mode_q<=mode_i every cycle.
- Stage 2 register: digit_sel_o, seg_o and dp_o are all computed from time_q/mode_q and the next scan state, so all three are always mutually coherent.
- Latency: a time_i/mode_i change sampled at edge n is reflected on seg_o at edge n+1, for the digit then selected.
- Digit split, by comparison/subtraction:
  - tens = 0..3, ones = time mod 10.
  - 0–9 → tens 0; 10–19 → tens 1; 20–29 → tens 2; 30–31 → tens 3.
- Segment codes:
  - 0=7'h3F, 1=7'h06, 2=7'h5B, 3=7'h4F, 4=7'h66, 5=7'h6D, 6=7'h7D, 7=7'h07, 8=7'h7F, 9=7'h6F.
  - dash=7'h40, blank=7'h00.
- Scan FSM (states ONES, TENS):
  - Scan counter counts 0..REFRESH_CYCLES-1; at terminal count it wraps to 0 and the state toggles.
  - digit_sel_o = 01 in ONES, 10 in TENS.
  - Default parameters give a strict alternation every cycle, starting with TENS on the first edge after reset release.
- Blink (IDLE only):
  - While mode_q==IDLE, the blink counter counts 0..BLINK_CYCLES-1 and the phase toggles at terminal count.
  - In any other mode the counter is held at 0 and the phase is held ON.
  - Entering IDLE therefore always starts with BLINK_CYCLES cycles visible.
  - Phase OFF → seg_o=blank and dp_o=0; the scan keeps running.
- Mode handling:
  - CLEAR and RUNNING: digits shown steadily.
  - RUNNING: dp_o=1 only while the ones digit is selected; dp_o=0 in all other modes.
- Illegal mode (mode_q not one of the three codes, including 000): both digits show dash, no blink, dp_o=0.
- Out-of-range time is impossible with 5 bits.
- time wrap 31→0 is shown directly as "0 0" (tens shows 0) unless the optional feature below is enabled.

Optional Feature:
- Macro: STOPWATCH_DISPLAY_LEAD_ZERO_BLANK_EN.
- Defined: when tens==0 and mode is legal, the tens digit shows blank (7'h00) instead of 7'h3F; the ones digit is unaffected, so time 0 shows " 0".
- Undefined: the tens digit always shows its numeral, including 0.

Test Plan:
- Reset: hold Rst_i=1 for 2 cycles with random inputs -> seg_o=00, digit_sel_o=01, dp_o=0. Release -> digit_sel_o alternates 10, 01, 10, ... each cycle.
- Digit conversion: time_i=23, mode_i=001 (RUNNING) -> within 2 edges, seg_o=5B while tens is selected and 4F while ones is selected. dp_o=1 only with ones. Repeat for time_i=9 (tens 3F, ones 6F) and 31 (4F/06).
- Latency: step time_i 4→15 at edge n -> seg_o first reflects 15 at edge n+1. digit_sel_o and seg_o are always consistent.
- IDLE blink: time_i=7, mode_i=100 -> 50 cycles normal output (3F/07), then 50 cycles seg_o=00, repeating. Switch to 010 mid-OFF -> the display is steady from the next edge.
- Illegal mode: mode_i=3'b011 and then 3'b000 -> both digits 40, dp_o=0, no blinking.
- Lead-zero blank (macro defined): time_i=5, mode_i=010 -> tens digit seg_o=00, ones=6D. Without the macro, tens=3F.
